mux8lut_frame_loader: RTL and testbench

// - Sequences frame-based configuration into a column of MUX8LUT_frame_config tiles. Each tile needs a
//   2-bit ConfigBits field (c0, c1).
// - Accepts configuration words over a valid/ready stream. Drives FrameData plus a one-hot FrameStrobe,
//   one frame at a time, with setup/hold guard cycles around every strobe.
// - Sits between the bitstream source (ConfigFSM side) and the tile column's frame latches.

---
 rtl/mux8lut_frame_loader_if.sv | 25 ++
 rtl/mux8lut_frame_loader.sv | 208 ++++++++++++++++++++
 tb/tb_mux8lut_frame_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux8lut_frame_loader_if.sv
// -----------------------------------------------------------------------------
// mux8lut_frame_loader_if
// Configuration-word stream between the bitstream source and the frame loader.
//   cfg_data   : configuration word (FRAME_BITS wide)
//   cfg_valid  : cfg_data holds a valid word
//   cfg_ready  : loader accepts the word this cycle
//   cfg_parity : odd parity over cfg_data (only with MUX8LUT_FRAME_LOADER_PARITY_EN)
// Modports: master = word source, slave = frame loader.
// -----------------------------------------------------------------------------
interface mux8lut_frame_loader_if #(
    parameter int FRAME_BITS = 32
);
    logic [FRAME_BITS-1:0] cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;
`ifdef MUX8LUT_FRAME_LOADER_PARITY_EN
    logic                  cfg_parity;

    modport master (output cfg_data, output cfg_valid, output cfg_parity, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, input cfg_parity, output cfg_ready);
`else
    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
`endif
endinterface

// File: rtl/mux8lut_frame_loader.sv
// -----------------------------------------------------------------------------
// mux8lut_frame_loader
// Loads one column of MUX8LUT_frame_config tiles frame by frame. Each accepted
// configuration word is presented on FrameData, then written by a one-hot
// FrameStrobe pulse framed by one setup and one hold cycle of stable data.
//
// Ports
//   CLK, resetn   : clock (rising edge) and asynchronous active-low reset
//   start         : begin a column load (only honoured in IDLE)
//   abort         : cancel the current load, back to IDLE on the next cycle
//   cfg           : configuration word stream (slave side)
//   FrameData     : registered frame data to the tile column
//   FrameStrobe   : one-hot frame write strobe, all-zero when not strobing
//   frame_idx     : frame currently being loaded
//   busy          : high in every state except IDLE
//   done          : one-cycle pulse after the last frame's hold cycle
//   err           : sticky parity error flag, cleared by the next start
//
// Optional feature: define MUX8LUT_FRAME_LOADER_PARITY_EN to check odd parity
// on every accepted word. A bad word is captured on FrameData but never
// strobed; the load stops in IDLE with err set. Without the macro err is 0.
// -----------------------------------------------------------------------------
module mux8lut_frame_loader #(
    parameter int FRAME_BITS    = 32,
    parameter int NUM_FRAMES    = 20,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                          CLK,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          abort,
    mux8lut_frame_loader_if.slave         cfg,
    output logic [FRAME_BITS-1:0]         FrameData,
    output logic [NUM_FRAMES-1:0]         FrameStrobe,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int IDX_W = $clog2(NUM_FRAMES);
    localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // One-hot strobe pattern for a frame index.
    function automatic logic [NUM_FRAMES-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_FRAMES-1:0] base;
        base   = {{(NUM_FRAMES-1){1'b0}}, 1'b1};
        onehot = base << idx;
    endfunction

`ifdef MUX8LUT_FRAME_LOADER_PARITY_EN
    // Odd parity: data plus parity bit must carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [FRAME_BITS-1:0] data, input logic par);
        odd_parity_ok = ((^{data, par}) == 1'b1);
    endfunction
`endif

    state_t                state_q,      state_d;
    logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
    logic [NUM_FRAMES-1:0] strobe_q,     strobe_d;
    logic [IDX_W-1:0]      frame_idx_q,  frame_idx_d;
    logic [CNT_W-1:0]      strb_cnt_q,   strb_cnt_d;
    logic                  cfg_ready_q,  cfg_ready_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic                  err_q,        err_d;
    logic                  hs_s;
    logic                  par_bad_s;

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d      = state_q;
        frame_data_d = frame_data_q;
        frame_idx_d  = frame_idx_q;
        strb_cnt_d   = strb_cnt_q;
        err_d        = err_q;
        // cfg_ready_q is only ever high in LOAD, so this is the LOAD handshake.
        hs_s         = cfg.cfg_valid & cfg_ready_q;
`ifdef MUX8LUT_FRAME_LOADER_PARITY_EN
        par_bad_s    = ~odd_parity_ok(cfg.cfg_data, cfg.cfg_parity);
`else
        par_bad_s    = 1'b0;
        err_d        = 1'b0;
`endif

        if (abort && (state_q != ST_IDLE)) begin
            // Abort leaves the partially written column as-is.
            state_d     = ST_IDLE;
            frame_idx_d = IDX_ZERO;
            strb_cnt_d  = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d     = ST_LOAD;
                        frame_idx_d = IDX_ZERO;
                        err_d       = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (hs_s) begin
                        frame_data_d = cfg.cfg_data;
                        if (par_bad_s) begin
                            state_d     = ST_IDLE;
                            frame_idx_d = IDX_ZERO;
                            err_d       = 1'b1;
                        end else begin
                            state_d = ST_SETUP;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_SETUP: begin
                    state_d    = ST_STROBE;
                    strb_cnt_d = CNT_ZERO;
                end
                ST_STROBE: begin
                    if (strb_cnt_q == CNT_LAST) begin
                        state_d    = ST_HOLD;
                        strb_cnt_d = CNT_ZERO;
                    end else begin
                        strb_cnt_d = strb_cnt_q + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    // The last frame never wraps the index; it leaves through DONE.
                    if (frame_idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_LOAD;
                        frame_idx_d = frame_idx_q + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d     = ST_IDLE;
                    frame_idx_d = IDX_ZERO;
                    strb_cnt_d  = CNT_ZERO;
                end
            endcase
        end

        // Outputs are registered copies of what the next state implies.
        if (state_d == ST_STROBE) begin
            strobe_d = onehot(frame_idx_d);
        end else begin
            strobe_d = {NUM_FRAMES{1'b0}};
        end
        cfg_ready_d = (state_d == ST_LOAD);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State and registered outputs; reset drops the strobe asynchronously.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            frame_data_q <= {FRAME_BITS{1'b0}};
            strobe_q     <= {NUM_FRAMES{1'b0}};
            frame_idx_q  <= IDX_ZERO;
            strb_cnt_q   <= CNT_ZERO;
            cfg_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_data_q <= frame_data_d;
            strobe_q     <= strobe_d;
            frame_idx_q  <= frame_idx_d;
            strb_cnt_q   <= strb_cnt_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign FrameData     = frame_data_q;
    assign FrameStrobe   = strobe_q;
    assign frame_idx     = frame_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mux8lut_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_mux8lut_frame_loader
// Two loaders (STROBE_CYCLES = 1 and 3) are driven by directed load scenarios.
// A timeline model predicts every output from handshake timestamps: a word
// accepted at edge h strobes on edges h+1..h+S and the next frame opens at
// edge h+S+2. Outputs are compared on every cycle, plus literal expectations
// for strobe counts, done timing and final data.
// -----------------------------------------------------------------------------
module tb_mux8lut_frame_loader;

    localparam int FB = 32;
    localparam int NF = 20;

    logic clk;
    logic resetn;
    logic             st [2];
    logic             ab [2];
    logic             vl [2];
    logic [FB-1:0]    dt [2];
    logic             rd [2];
    logic [FB-1:0]    fd [2];
    logic [NF-1:0]    fs [2];
    logic [4:0]       fi [2];
    logic             bz [2];
    logic             dn [2];
    logic             er [2];

    mux8lut_frame_loader_if #(.FRAME_BITS(FB)) if0 ();
    mux8lut_frame_loader_if #(.FRAME_BITS(FB)) if1 ();

    assign if0.cfg_data  = dt[0];
    assign if0.cfg_valid = vl[0];
    assign rd[0]         = if0.cfg_ready;
    assign if1.cfg_data  = dt[1];
    assign if1.cfg_valid = vl[1];
    assign rd[1]         = if1.cfg_ready;
`ifdef MUX8LUT_FRAME_LOADER_PARITY_EN
    assign if0.cfg_parity = ~(^dt[0]);
    assign if1.cfg_parity = ~(^dt[1]);
`endif

    mux8lut_frame_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF), .STROBE_CYCLES(1)) dut0 (
        .CLK(clk), .resetn(resetn), .start(st[0]), .abort(ab[0]), .cfg(if0),
        .FrameData(fd[0]), .FrameStrobe(fs[0]), .frame_idx(fi[0]),
        .busy(bz[0]), .done(dn[0]), .err(er[0])
    );

    mux8lut_frame_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF), .STROBE_CYCLES(3)) dut1 (
        .CLK(clk), .resetn(resetn), .start(st[1]), .abort(ab[1]), .cfg(if1),
        .FrameData(fd[1]), .FrameStrobe(fs[1]), .frame_idx(fi[1]),
        .busy(bz[1]), .done(dn[1]), .err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Timeline model state per instance.
    bit            m_busy  [2];
    bit            m_wait  [2];
    int            m_idx   [2];
    int            m_hs    [2];
    int            m_done_e[2];
    int            m_start_e[2];
    int            m_hs3   [2];
    logic [FB-1:0] m_fd    [2];
    logic [NF-1:0] m_exp_fs[2];

    // Observations of the DUTs for literal checks.
    int n_strb[2];
    int n_done[2];
    int done_edge[2];
    int strb3_edge[2];

    function automatic int scyc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0h required=%0h edge=%0d", nm, inst, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_wait[i] = 1'b0; m_idx[i] = 0;
            m_hs[i] = -100; m_done_e[i] = -100; m_fd[i] = '0; m_exp_fs[i] = '0;
        end
    endtask

    task automatic model_step(input int i, input int e);
        if (m_busy[i] && (m_done_e[i] == e - 1)) begin
            m_busy[i] = 1'b0;
        end else if (!m_busy[i]) begin
            if (st[i] && !ab[i]) begin
                m_busy[i] = 1'b1; m_wait[i] = 1'b1; m_idx[i] = 0; m_hs[i] = -100;
                m_start_e[i] = e;
            end
        end else if (ab[i]) begin
            m_busy[i] = 1'b0; m_wait[i] = 1'b0; m_idx[i] = 0; m_hs[i] = -100;
        end else if (m_wait[i]) begin
            if (vl[i]) begin
                m_wait[i] = 1'b0; m_hs[i] = e; m_fd[i] = dt[i];
                if (m_idx[i] == 3) m_hs3[i] = e;
            end
        end else if (e == m_hs[i] + scyc(i) + 2) begin
            if (m_idx[i] == NF - 1) m_done_e[i] = e;
            else begin
                m_idx[i] = m_idx[i] + 1; m_wait[i] = 1'b1;
            end
        end
    endtask

    // Model update at every edge, compare 1 time unit later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                model_reset();
            end else begin
                edge_n++;
                for (int i = 0; i < 2; i++) model_step(i, edge_n);
                #1;
                for (int i = 0; i < 2; i++) begin
                    logic [NF-1:0] one;
                    one = {{(NF-1){1'b0}}, 1'b1};
                    if (m_busy[i] && !m_wait[i] && edge_n >= m_hs[i] + 1 && edge_n <= m_hs[i] + scyc(i))
                        m_exp_fs[i] = one << m_idx[i];
                    else
                        m_exp_fs[i] = '0;
                    chk("cfg_ready", i, 64'(rd[i]), 64'(m_wait[i]));
                    chk("busy", i, 64'(bz[i]), 64'(m_busy[i]));
                    chk("done", i, 64'(dn[i]), 64'(m_done_e[i] == edge_n));
                    chk("frame_idx", i, 64'(fi[i]), 64'(m_idx[i]));
                    chk("FrameData", i, 64'(fd[i]), 64'(m_fd[i]));
                    chk("FrameStrobe", i, 64'(fs[i]), 64'(m_exp_fs[i]));
                    chk("err", i, 64'(er[i]), 64'd0);
                    if (fs[i] != '0) n_strb[i]++;
                    if (fs[i][3] && strb3_edge[i] < 0) strb3_edge[i] = edge_n;
                    if (dn[i]) begin
                        n_done[i]++;
                        if (done_edge[i] < 0) done_edge[i] = edge_n;
                    end
                end
            end
        end
    end

    task automatic clear_obs(input int i);
        n_strb[i] = 0; n_done[i] = 0; done_edge[i] = -1; strb3_edge[i] = -1; m_hs3[i] = -1;
    endtask

    // Drive one load on instance i; words are 0x00..0x13 indexed by frame.
    task automatic run_load(input int i, input int stall_at, input int abort_at, input int restart_at);
        int  stalls;
        bit  aborted, restarted, finished;
        clear_obs(i);
        stalls = 0; aborted = 1'b0; restarted = 1'b0; finished = 1'b0;
        st[i] = 1'b1; vl[i] = 1'b0;
        @(negedge clk);
        st[i] = 1'b0;
        for (int b = 0; b < 400; b++) begin
            dt[i] = FB'(m_idx[i]);
            vl[i] = 1'b1; ab[i] = 1'b0; st[i] = 1'b0;
            if (m_wait[i] && m_idx[i] == stall_at && stalls < 5) begin
                vl[i] = 1'b0; stalls++;
            end
            if (!aborted && m_idx[i] == abort_at && m_exp_fs[i][abort_at]) begin
                ab[i] = 1'b1; aborted = 1'b1;
            end
            if (!restarted && m_idx[i] == restart_at && m_busy[i]) begin
                st[i] = 1'b1; restarted = 1'b1;
            end
            @(negedge clk);
            if (!m_busy[i]) begin
                finished = 1'b1;
                break;
            end
        end
        vl[i] = 1'b0; ab[i] = 1'b0; st[i] = 1'b0;
        if (!finished) begin
            checks++; errors++;
            $display("FAIL load_timeout inst%0d actual=busy required=idle within 400 cycles", i);
        end
    endtask

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ab[i] = 1'b0; vl[i] = 1'b0; dt[i] = '0;
        end
        repeat (3) @(negedge clk);
        // Reset values.
        for (int i = 0; i < 2; i++) begin
            chk("rst_FrameData", i, 64'(fd[i]), 64'd0);
            chk("rst_FrameStrobe", i, 64'(fs[i]), 64'd0);
            chk("rst_frame_idx", i, 64'(fi[i]), 64'd0);
            chk("rst_cfg_ready", i, 64'(rd[i]), 64'd0);
            chk("rst_busy", i, 64'(bz[i]), 64'd0);
            chk("rst_done", i, 64'(dn[i]), 64'd0);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Full load, S=1: 20 strobes, done 80 edges after the start edge.
        run_load(0, -1, -1, -1);
        chk("full_strobes", 0, 64'(n_strb[0]), 64'd20);
        chk("full_dones", 0, 64'(n_done[0]), 64'd1);
        chk("full_done_time", 0, 64'(done_edge[0] - m_start_e[0]), 64'd80);
        chk("full_last_data", 0, 64'(fd[0]), 64'h13);
        chk("full_idle", 0, 64'(bz[0]), 64'd0);

        // Backpressure before frame 3: five extra cycles; strobe on the edge
        // after the handshake edge (second cycle counting the handshake cycle).
        run_load(0, 3, -1, -1);
        chk("bp_strobes", 0, 64'(n_strb[0]), 64'd20);
        chk("bp_done_time", 0, 64'(done_edge[0] - m_start_e[0]), 64'd85);
        chk("bp_strobe_delay", 0, 64'(strb3_edge[0] - m_hs3[0]), 64'd1);

        // Abort during strobe of frame 7, then a fresh load from frame 0.
        run_load(0, -1, 7, -1);
        chk("abort_dones", 0, 64'(n_done[0]), 64'd0);
        chk("abort_strobes", 0, 64'(n_strb[0]), 64'd8);
        chk("abort_strobe_clear", 0, 64'(fs[0]), 64'd0);
        chk("abort_busy", 0, 64'(bz[0]), 64'd0);
        chk("abort_idx", 0, 64'(fi[0]), 64'd0);
        run_load(0, -1, -1, -1);
        chk("reload_strobes", 0, 64'(n_strb[0]), 64'd20);
        chk("reload_done_time", 0, 64'(done_edge[0] - m_start_e[0]), 64'd80);

        // start while busy at frame 10 is ignored.
        run_load(0, -1, -1, 10);
        chk("busy_start_strobes", 0, 64'(n_strb[0]), 64'd20);
        chk("busy_start_dones", 0, 64'(n_done[0]), 64'd1);
        chk("busy_start_done_time", 0, 64'(done_edge[0] - m_start_e[0]), 64'd80);

        // start and abort together in IDLE: stay idle.
        st[0] = 1'b1; ab[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0; ab[0] = 1'b0;
        chk("start_abort_idle", 0, 64'(bz[0]), 64'd0);
        chk("start_abort_ready", 0, 64'(rd[0]), 64'd0);

        // STROBE_CYCLES=3: 60 strobe cycles, frame period 6.
        run_load(1, -1, -1, -1);
        chk("s3_strobes", 1, 64'(n_strb[1]), 64'd60);
        chk("s3_done_time", 1, 64'(done_edge[1] - m_start_e[1]), 64'd120);
        chk("s3_last_data", 1, 64'(fd[1]), 64'h13);

        // Asynchronous reset during frame 5 strobe.
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0; vl[0] = 1'b1;
        for (int b = 0; b < 100; b++) begin
            dt[0] = FB'(m_idx[0]);
            if (m_exp_fs[0][5]) break;
            @(negedge clk);
        end
        chk("pre_reset_strobe", 0, 64'(fs[0]), 64'h20);
        resetn = 1'b0;
        #1;
        chk("async_rst_strobe", 0, 64'(fs[0]), 64'd0);
        chk("async_rst_busy", 0, 64'(bz[0]), 64'd0);
        chk("async_rst_idx", 0, 64'(fi[0]), 64'd0);
        chk("async_rst_data", 0, 64'(fd[0]), 64'd0);
        vl[0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
